selector_41: RTL and testbench



---
 rtl/selector_41.sv | 43 ++++
 tb/tb_selector_41.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/selector_41.sv
// Four-way 4-bit data selector with a combinational output and a one-hot select decode.
// An enable-gated register also holds a copy of the selected word.
module selector_41 (
  input  logic [3:0] iC0,
  input  logic [3:0] iC1,
  input  logic [3:0] iC2,
  input  logic [3:0] iC3,
  input  logic       iS1,
  input  logic       iS0,
  output logic [3:0] oZ,
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iEn,
  output logic [3:0] oZq,
  output logic [3:0] oSel
);

  localparam int DATA_W = 4;

  logic [DATA_W-1:0] term0, term1, term2, term3;
  logic [DATA_W-1:0] zQ_p1;

  // Sum-of-products form: each product term gates one input word by its select minterm.
  assign term0 = {DATA_W{~iS1 & ~iS0}} & iC0;
  assign term1 = {DATA_W{~iS1 &  iS0}} & iC1;
  assign term2 = {DATA_W{ iS1 & ~iS0}} & iC2;
  assign term3 = {DATA_W{ iS1 &  iS0}} & iC3;

  assign oZ   = term0 | term1 | term2 | term3;
  assign oSel = 4'b0001 << {iS1, iS0};

  // Stage p1: registered copy of the selected word; reset wins over the enable.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      zQ_p1 <= '0;
    end else if (iEn) begin
      zQ_p1 <= oZ;
    end
  end

  assign oZq = zQ_p1;

endmodule

// File: tb/tb_selector_41.sv
// Self-checking bench for selector_41: combinational select/decode checks plus a
// scoreboard of expected registered outputs pushed at each edge and popped after it.
module tb_selector_41;

  logic [3:0] iC0, iC1, iC2, iC3;
  logic       iS1, iS0;
  logic [3:0] oZ;
  logic       iClk, iReset, iEn;
  logic [3:0] oZq;
  logic [3:0] oSel;

  int nChecks = 0;
  int nFail   = 0;

  logic [3:0] sbQ[$];
  logic [3:0] refQ;

  selector_41 dut (
    .iC0(iC0), .iC1(iC1), .iC2(iC2), .iC3(iC3),
    .iS1(iS1), .iS0(iS0), .oZ(oZ),
    .iClk(iClk), .iReset(iReset), .iEn(iEn),
    .oZq(oZq), .oSel(oSel)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic logic [3:0] modelZ(input logic [3:0] c0, c1, c2, c3,
                                        input logic s1, s0);
    case ({s1, s0})
      2'b00:   return c0;
      2'b01:   return c1;
      2'b10:   return c2;
      default: return c3;
    endcase
  endfunction

  function automatic logic [3:0] modelSel(input logic s1, s0);
    case ({s1, s0})
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0010;
      2'b10:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Predict the register update from the inputs present now, then take one edge.
  task automatic tick();
    if (iReset)   refQ = 4'b0000;
    else if (iEn) refQ = modelZ(iC0, iC1, iC2, iC3, iS1, iS0);
    sbQ.push_back(refQ);
    @(posedge iClk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [3:0] expZ [4];
    expZ[0] = 4'b0001; expZ[1] = 4'b0010; expZ[2] = 4'b0100; expZ[3] = 4'b1000;
    iC0 = 4'b0001; iC1 = 4'b0010; iC2 = 4'b0100; iC3 = 4'b1000;
    for (int s = 0; s < 4; s++) begin
      {iS1, iS0} = 2'(s);
      #10;
      nChecks++;
      if (oZ !== expZ[s]) begin
        nFail++;
        $display("FAIL sweep_z s=%0d got=%b want=%b", s, oZ, expZ[s]);
      end
      nChecks++;
      if (oSel !== expZ[s]) begin
        nFail++;
        $display("FAIL sweep_sel s=%0d got=%b want=%b", s, oSel, expZ[s]);
      end
    end
  endtask

  task automatic test_data_change();
    {iS1, iS0} = 2'b10;
    iC2 = 4'b0100;
    #3;
    iC2 = 4'b1011;
    #3;
    nChecks++;
    if (oZ !== 4'b1011) begin
      nFail++;
      $display("FAIL data_follow got=%b want=%b", oZ, 4'b1011);
    end
    iC0 = 4'b1111; iC1 = 4'b0110; iC3 = 4'b0011;
    #3;
    nChecks++;
    if (oZ !== 4'b1011) begin
      nFail++;
      $display("FAIL data_other_inputs got=%b want=%b", oZ, 4'b1011);
    end
    iC0 = 4'b0001; iC1 = 4'b0010; iC2 = 4'b0100; iC3 = 4'b1000;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    {iS1, iS0} = 2'b11;
    iEn = 1'b1;
    iReset = 1'b1;
    tick();
    exp = sbQ.pop_front();
    nChecks++;
    if (oZq !== exp || exp !== 4'b0000) begin
      nFail++;
      $display("FAIL reset_zq got=%b want=%b", oZq, 4'b0000);
    end
    nChecks++;
    if (oZ !== 4'b1000) begin
      nFail++;
      $display("FAIL reset_z got=%b want=%b", oZ, 4'b1000);
    end
    iReset = 1'b0;
  endtask

  task automatic test_capture();
    logic [3:0] exp;
    iReset = 1'b0;
    iEn = 1'b1;
    {iS1, iS0} = 2'b01;
    iC1 = 4'b0010;
    tick();
    exp = sbQ.pop_front();
    nChecks++;
    if (oZq !== exp) begin
      nFail++;
      $display("FAIL capture_zq got=%b want=%b", oZq, exp);
    end
    iEn = 1'b0;
    {iS1, iS0} = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = sbQ.pop_front();
      nChecks++;
      if (oZq !== exp || oZq !== 4'b0010) begin
        nFail++;
        $display("FAIL hold_zq cyc=%0d got=%b want=%b", i, oZq, exp);
      end
    end
    nChecks++;
    if (oZ !== 4'b1000) begin
      nFail++;
      $display("FAIL hold_z got=%b want=%b", oZ, 4'b1000);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    iEn = 1'b1;
    {iS1, iS0} = 2'b11;
    tick();
    exp = sbQ.pop_front();
    nChecks++;
    if (oZq !== exp || oZq !== 4'b1000) begin
      nFail++;
      $display("FAIL mid_load got=%b want=%b", oZq, exp);
    end
    iReset = 1'b1;
    tick();
    exp = sbQ.pop_front();
    nChecks++;
    if (oZq !== exp || oZq !== 4'b0000) begin
      nFail++;
      $display("FAIL mid_reset got=%b want=%b", oZq, 4'b0000);
    end
    iReset = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] exp;
    for (int v = 0; v < 200; v++) begin
      iC0 = 4'($urandom); iC1 = 4'($urandom);
      iC2 = 4'($urandom); iC3 = 4'($urandom);
      {iS1, iS0} = 2'($urandom);
      iEn = 1'($urandom);
      iReset = ($urandom_range(0, 9) == 0);
      #1;
      nChecks++;
      if (oZ !== modelZ(iC0, iC1, iC2, iC3, iS1, iS0)) begin
        nFail++;
        $display("FAIL rand_z v=%0d got=%b want=%b", v, oZ,
                 modelZ(iC0, iC1, iC2, iC3, iS1, iS0));
      end
      nChecks++;
      if (oSel !== modelSel(iS1, iS0)) begin
        nFail++;
        $display("FAIL rand_sel v=%0d got=%b want=%b", v, oSel, modelSel(iS1, iS0));
      end
      tick();
      exp = sbQ.pop_front();
      nChecks++;
      if (oZq !== exp) begin
        nFail++;
        $display("FAIL rand_zq v=%0d got=%b want=%b", v, oZq, exp);
      end
    end
    iReset = 1'b0;
  endtask

  initial begin
    iC0 = '0; iC1 = '0; iC2 = '0; iC3 = '0;
    iS1 = 1'b0; iS0 = 1'b0;
    iReset = 1'b0; iEn = 1'b0;
    refQ = 4'bxxxx;
    test_comb_sweep();
    test_data_change();
    @(posedge iClk);
    #1;
    test_reset();
    test_capture();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
